// File: rtl/csa_pkg.sv
// Shared types and helpers for the shared carry-skip adder arbiter:
// operation encoding, result-slot states and round-robin grant functions.
package csa_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  // Helpers operate on a fixed maximum requester count; callers zero-extend.
  localparam int unsigned MAXREQ = 32;
  localparam int unsigned MAXIDW = 5;

  typedef logic [MAXREQ-1:0] req_vec_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // One-hot pick of the first valid index scanning ptr, ptr+1, ... mod nreq.
  function automatic req_vec_t rr_pick(input req_vec_t valid,
                                       input int unsigned ptr,
                                       input int unsigned nreq);
    req_vec_t    grant;
    logic        found;
    int unsigned pos;
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAXREQ; i++) begin
      pos = ptr + i;
      if (pos >= nreq) pos = pos - nreq;
      if ((i < nreq) && !found && valid[pos[MAXIDW-1:0]]) begin
        grant[pos[MAXIDW-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return grant;
  endfunction

  function automatic logic [MAXIDW-1:0] onehot2idx(input req_vec_t onehot);
    logic [MAXIDW-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAXREQ; i++) begin
      if (onehot[i]) idx = idx | i[MAXIDW-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/csa_rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester from rr_ptr onward and
// moves rr_ptr past the winner whenever a transfer completes.
module csa_rr_arbiter
  import csa_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          valid,
  input  logic                     enable,
  input  logic                     advance,
  output logic [NREQ-1:0]          grant,
  output logic [$clog2(NREQ)-1:0]  grant_idx
);

  localparam int unsigned IDW = $clog2(NREQ);

  logic [IDW-1:0]    rr_ptr;
  req_vec_t          pick;
  logic [MAXIDW-1:0] pick_idx;

  always_comb begin
    pick     = rr_pick(req_vec_t'(valid), 32'(rr_ptr), NREQ);
    pick_idx = onehot2idx(pick);
  end

  assign grant     = enable ? pick[NREQ-1:0] : '0;
  assign grant_idx = pick_idx[IDW-1:0];

  // Explicit wrap keeps non-power-of-2 NREQ inside the valid index range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/csa_skip_adder.sv
// Combinational carry-skip adder built from 4-bit ripple blocks; a block
// whose bits all propagate forwards its incoming carry directly.
module csa_skip_adder #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int unsigned NB = N / 4;

  always_comb begin
    logic [NB:0]  blk_c;
    logic [N-1:0] s;
    logic         rc;
    logic         prop;
    blk_c    = '0;
    s        = '0;
    rc       = 1'b0;
    prop     = 1'b0;
    blk_c[0] = cin;
    for (int unsigned j = 0; j < NB; j++) begin
      rc   = blk_c[j];
      prop = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
        s[4*j+i] = a[4*j+i] ^ b[4*j+i] ^ rc;
        rc       = (a[4*j+i] & b[4*j+i]) | (rc & (a[4*j+i] ^ b[4*j+i]));
        prop     = prop & (a[4*j+i] ^ b[4*j+i]);
      end
      blk_c[j+1] = prop ? blk_c[j] : rc;
    end
    sum  = s;
    cout = blk_c[NB];
  end

endmodule

// File: rtl/csa_shared_arbiter.sv
// Shares one carry-skip adder among NREQ requesters: round-robin grant,
// operand mux with subtract inversion, and a one-deep registered result slot.
module csa_shared_arbiter
  import csa_pkg::*;
#(
  parameter int unsigned N    = 32,
  parameter int unsigned NREQ = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_sub,
  input  logic [NREQ*N-1:0]        req_a,
  input  logic [NREQ*N-1:0]        req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [N-1:0]             rsp_sum,
  output logic                     rsp_cout,
  output logic                     rsp_of
);

  localparam int unsigned IDW = $clog2(NREQ);

  slot_state_t     slot_q;
  slot_state_t     slot_d;
  logic            slot_free;
  logic            transfer;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic [N-1:0]    op_a;
  logic [N-1:0]    op_b;
  logic            op_sub;
  logic [N-1:0]    csa_b;
  logic [N-1:0]    csa_sum;
  logic            csa_cout;
  logic            csa_of;

  assign rsp_valid = (slot_q == SLOT_FULL);
  assign slot_free = !rsp_valid || rsp_ready;

  // rst_n gating holds req_ready low for the whole reset window.
  csa_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (req_valid),
    .enable    (slot_free & rst_n),
    .advance   (transfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign transfer  = |(req_valid & req_ready);

  always_comb begin
    op_a   = '0;
    op_b   = '0;
    op_sub = ADD;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        op_a   = req_a[k*N +: N];
        op_b   = req_b[k*N +: N];
        op_sub = req_sub[k];
      end
    end
  end

  assign csa_b = (op_sub == SUB) ? ~op_b : op_b;

  csa_skip_adder #(
    .N (N)
  ) u_csa (
    .a    (op_a),
    .b    (csa_b),
    .cin  (op_sub),
    .sum  (csa_sum),
    .cout (csa_cout)
  );

  assign csa_of = (csa_sum[N-1] ^ op_a[N-1]) & ~(op_a[N-1] ^ csa_b[N-1]);

  always_comb begin
    slot_d = slot_q;
    case (slot_q)
      SLOT_EMPTY: if (transfer) slot_d = SLOT_FULL;
      SLOT_FULL: begin
        if (transfer)       slot_d = SLOT_FULL;
        else if (rsp_ready) slot_d = SLOT_EMPTY;
      end
      default: slot_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= SLOT_EMPTY;
    end else begin
      slot_q <= slot_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id   <= '0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_of   <= 1'b0;
    end else if (transfer) begin
      rsp_id   <= grant_idx;
      rsp_sum  <= csa_sum;
      rsp_cout <= csa_cout;
      rsp_of   <= csa_of;
    end
  end

endmodule

// File: tb/tb_csa_shared_arbiter.sv
// Bench for csa_shared_arbiter: vector table, round-robin, back-pressure and
// async-reset sequences, with a scoreboard fed by a reference grant/arith model.
module tb_csa_shared_arbiter;

  localparam int unsigned N    = 32;
  localparam int unsigned NREQ = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_sub;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [N-1:0]      rsp_sum;
  logic              rsp_cout;
  logic              rsp_of;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] sum;
    logic        cout;
    logic        of;
  } res_t;

  typedef struct {
    logic [1:0]  port;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic        cout;
    logic        of;
  } vec_t;

  res_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned mptr  = 0;
  vec_t        vt[9];

  csa_shared_arbiter #(
    .N    (N),
    .NREQ (NREQ)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sub   (req_sub),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_of    (rsp_of)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [1:0] id, input logic sub,
                                 input logic [31:0] a, input logic [31:0] b);
    res_t        r;
    logic [31:0] bb;
    logic [32:0] t;
    bb     = sub ? ~b : b;
    t      = {1'b0, a} + {1'b0, bb} + {32'd0, sub};
    r.id   = id;
    r.sum  = t[31:0];
    r.cout = t[32];
    r.of   = (t[31] ^ a[31]) & ~(a[31] ^ bb[31]);
    return r;
  endfunction

  // Reference model: own slot occupancy and rr pointer, compared every cycle.
  always @(negedge clk) begin : mon
    res_t        e;
    logic        full;
    logic        sf;
    logic        found;
    logic [3:0]  eg;
    int unsigned k;
    int unsigned kk;
    if (!rst_n) begin
      sb.delete();
      mptr = 0;
    end else begin
      full = (sb.size() != 0);
      chk("sb_valid", 64'(rsp_valid), 64'(full));
      if (full) begin
        e = sb[0];
        chk("sb_id",   64'(rsp_id),   64'(e.id));
        chk("sb_sum",  64'(rsp_sum),  64'(e.sum));
        chk("sb_cout", 64'(rsp_cout), 64'(e.cout));
        chk("sb_of",   64'(rsp_of),   64'(e.of));
        if (rsp_ready) void'(sb.pop_front());
      end
      sf    = !full || rsp_ready;
      eg    = '0;
      found = 1'b0;
      kk    = 0;
      if (sf) begin
        for (int unsigned i = 0; i < NREQ; i++) begin
          k = (mptr + i) % NREQ;
          if (!found && req_valid[k]) begin
            eg[k] = 1'b1;
            found = 1'b1;
            kk    = k;
          end
        end
      end
      chk("sb_ready", 64'(req_ready), 64'(eg));
      if (found) begin
        sb.push_back(model(2'(kk), req_sub[kk], req_a[kk*32 +: 32], req_b[kk*32 +: 32]));
        mptr = (kk + 1) % NREQ;
      end
    end
  end

  task automatic set_port(input int unsigned k, input logic s,
                          input logic [31:0] a, input logic [31:0] b);
    req_sub[k]         = s;
    req_a[k*32 +: 32]  = a;
    req_b[k*32 +: 32]  = b;
  endtask

  task automatic do_vec(input vec_t v, input int unsigned n);
    logic got;
    set_port(32'(v.port), v.sub, v.a, v.b);
    req_valid = 4'b0001 << v.port;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      got = req_ready[v.port];
    end
    chk($sformatf("vec%0d_ready", n), 64'(got), 64'd1);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk($sformatf("vec%0d_valid", n), 64'(rsp_valid), 64'd1);
    chk($sformatf("vec%0d_id", n),    64'(rsp_id),    64'(v.port));
    chk($sformatf("vec%0d_sum", n),   64'(rsp_sum),   64'(v.sum));
    chk($sformatf("vec%0d_cout", n),  64'(rsp_cout),  64'(v.cout));
    chk($sformatf("vec%0d_of", n),    64'(rsp_of),    64'(v.of));
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t pre;
    //          port  sub   a             b             sum           cout  of
    vt[0] = '{2'd2, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0};
    vt[1] = '{2'd0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
    vt[2] = '{2'd1, 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vt[3] = '{2'd3, 1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vt[4] = '{2'd1, 1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0};
    vt[5] = '{2'd0, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
    vt[6] = '{2'd2, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1};
    vt[7] = '{2'd0, 1'b0, 32'h0F0F_0F0F, 32'hF0F0_F0F1, 32'h0000_0000, 1'b1, 1'b0};
    vt[8] = '{2'd3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0};

    rst_n     = 1'b0;
    req_valid = '1;
    req_sub   = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;

    // Reset with every port requesting: nothing may be accepted.
    repeat (3) begin
      @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    end
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    rst_n     = 1'b1;
    @(negedge clk);
    chk("idle_valid", 64'(rsp_valid), 64'd0);
    chk("idle_ready", 64'(req_ready), 64'd0);
    chk("idle_id",    64'(rsp_id),    64'd0);
    chk("idle_sum",   64'(rsp_sum),   64'd0);
    chk("idle_cout",  64'(rsp_cout),  64'd0);
    chk("idle_of",    64'(rsp_of),    64'd0);
    @(posedge clk); #1;

    foreach (vt[i]) do_vec(vt[i], 32'(i));

    // Round-robin: pointer sits at 0 after the last table entry (port 3).
    for (int unsigned k = 0; k < NREQ; k++)
      set_port(k, k[0], 32'h1000_0000 * k + 32'h55, 32'h0000_0100 + k);
    req_valid = '1;
    for (int unsigned i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) chk("rr_first_ready", 64'(req_ready), 64'b0001);
      else begin
        chk($sformatf("rr%0d_valid", i), 64'(rsp_valid), 64'd1);
        chk($sformatf("rr%0d_id", i),    64'(rsp_id),    64'((i - 1) % NREQ));
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("rr_last_id", 64'(rsp_id), 64'd3);
    @(posedge clk); #1;

    // Move the pointer to 1, then back-pressure with ports 1 and 3 pending.
    pre = '{2'd0, 1'b0, 32'h2, 32'h3, 32'h5, 1'b0, 1'b0};
    do_vec(pre, 99);
    set_port(1, 1'b0, 32'h10, 32'h20);
    set_port(3, 1'b1, 32'h100, 32'h1);
    rsp_ready = 1'b0;
    req_valid = 4'b1010;
    @(negedge clk);
    chk("bp_first_ready", 64'(req_ready), 64'b0010);
    @(posedge clk); #1;
    req_valid = 4'b1000;
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_valid", i), 64'(rsp_valid), 64'd1);
      chk($sformatf("bp%0d_id", i),    64'(rsp_id),    64'd1);
      chk($sformatf("bp%0d_sum", i),   64'(rsp_sum),   64'h30);
      chk($sformatf("bp%0d_ready", i), 64'(req_ready), 64'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(req_ready), 64'b1000);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("bp_next_valid", 64'(rsp_valid), 64'd1);
    chk("bp_next_id",    64'(rsp_id),    64'd3);
    chk("bp_next_sum",   64'(rsp_sum),   64'hFF);
    chk("bp_next_cout",  64'(rsp_cout),  64'd1);
    @(posedge clk); #1;

    // Async reset while a result is held; first grant afterwards goes to port 0.
    rsp_ready = 1'b0;
    set_port(2, 1'b0, 32'h40, 32'h2);
    req_valid = 4'b0100;
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("mid_held_valid", 64'(rsp_valid), 64'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_sum",   64'(rsp_sum),   64'd0);
    chk("mid_rst_id",    64'(rsp_id),    64'd0);
    req_valid = '1;
    @(negedge clk);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(req_ready), 64'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("post_rst_valid", 64'(rsp_valid), 64'd1);
    chk("post_rst_id",    64'(rsp_id),    64'd0);
    repeat (2) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
